// File: rtl/pipe_sequencer.sv
// Central stall/flush sequencer for the 5-stage pipeline: per-cycle write enables, flushes and mult/div start.
// Optional stall performance counter enabled by defining PIPE_SEQUENCER_PERF_EN.
module pipe_sequencer #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             md_done,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             md_go,
  output logic             md_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_MD_WAIT  = 2'd2;

  localparam int TMR_W = $clog2(MD_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  logic [1:0]       state_reg, state_next;
  logic             md_served_reg, md_served_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             md_err_reg, md_err_next;

  always_comb begin
    pc_we          = 1'b1;
    if_id_we       = 1'b1;
    ex_mem_we      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    md_go          = 1'b0;
    state_next     = state_reg;
    md_served_next = md_served_reg;
    timer_next     = timer_reg;
    md_err_next    = md_err_reg;

    case (state_reg)
      ST_RUN: begin
        if (dmem_req && !dmem_ack) begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          ex_mem_we  = 1'b0;
          state_next = ST_MEM_WAIT;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (md_start && !md_served_reg) begin
          pc_we      = 1'b0;
          if_id_we   = 1'b0;
          ex_mem_we  = 1'b0;
          md_go      = 1'b1;
          timer_next = '0;
          state_next = ST_MD_WAIT;
        end else if (stall_req) begin
          pc_we       = 1'b0;
          if_id_we    = 1'b0;
          id_ex_flush = 1'b1;
        end
        // Once the served mult/div leaves EX it can no longer re-trigger.
        if (ex_mem_we) begin
          md_served_next = 1'b0;
        end
      end

      ST_MEM_WAIT: begin
        pc_we     = dmem_ack;
        if_id_we  = dmem_ack;
        ex_mem_we = dmem_ack;
        if (dmem_ack) begin
          state_next = ST_RUN;
        end
      end

      ST_MD_WAIT: begin
        pc_we      = 1'b0;
        if_id_we   = 1'b0;
        ex_mem_we  = 1'b0;
        timer_next = timer_reg + 1'b1;
        // A done in the timeout cycle wins, so no error is flagged.
        if (md_done) begin
          state_next     = ST_RUN;
          md_served_next = 1'b1;
          timer_next     = '0;
        end else if (timer_reg == TMR_LAST) begin
          state_next     = ST_RUN;
          md_served_next = 1'b1;
          md_err_next    = 1'b1;
          timer_next     = '0;
        end
      end

      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_RUN;
      md_served_reg <= 1'b0;
      timer_reg     <= '0;
      md_err_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      md_served_reg <= md_served_next;
      timer_reg     <= timer_next;
      md_err_reg    <= md_err_next;
    end
  end

  assign state  = state_reg;
  assign md_err = md_err_reg;

`ifdef PIPE_SEQUENCER_PERF_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (!pc_we && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign stall_cycles = stall_cnt_reg;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: cycle table plus hand sequences for timeout, reset and counter saturation.
module tb_pipe_sequencer;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Input bit order: {stall_req, branch_taken, md_start, md_done, dmem_req, dmem_ack}
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_STL  = 6'b100000;
  localparam logic [5:0] I_BR   = 6'b010000;
  localparam logic [5:0] I_MDS  = 6'b001000;
  localparam logic [5:0] I_MDD  = 6'b000100;
  localparam logic [5:0] I_DREQ = 6'b000010;
  localparam logic [5:0] I_DACK = 6'b000001;

  // Output order: {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, md_go, md_err, state[1:0]}
  localparam logic [8:0] O_RUN   = 9'b110010000;
  localparam logic [8:0] O_STALL = 9'b000110000;
  localparam logic [8:0] O_FLUSH = 9'b111110000;
  localparam logic [8:0] O_GO    = 9'b000001000;
  localparam logic [8:0] O_MDW   = 9'b000000010;
  localparam logic [8:0] O_DFRZ  = 9'b000000000;
  localparam logic [8:0] O_MEMW  = 9'b000000001;
  localparam logic [8:0] O_MACK  = 9'b110010001;

  typedef struct {
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_req = 1'b0, branch_taken = 1'b0, md_start = 1'b0;
  logic md_done = 1'b0, dmem_req = 1'b0, dmem_ack = 1'b0;
  logic pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, md_go, md_err;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic perf_en;
  vec_t vecs[22];

  pipe_sequencer #(.MD_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stall_req(stall_req), .branch_taken(branch_taken),
    .md_start(md_start), .md_done(md_done),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .if_id_we(if_id_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_we(ex_mem_we), .md_go(md_go), .md_err(md_err),
    .state(state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] outs();
    return {pc_we, if_id_we, if_id_flush, id_ex_flush, ex_mem_we, md_go, md_err, state};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {stall_req, branch_taken, md_start, md_done, dmem_req, dmem_ack} = in;
  endtask

  task automatic step(input logic [5:0] in);
    @(negedge clk);
    drive(in);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(I_NONE);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PIPE_SEQUENCER_PERF_EN
    perf_en = 1'b1;
`else
    perf_en = 1'b0;
`endif
    exp_cnt = '0;

    vecs[0]  = '{I_NONE, O_RUN};
    vecs[1]  = '{I_STL, O_STALL};
    vecs[2]  = '{I_NONE, O_RUN};
    vecs[3]  = '{I_BR | I_STL, O_FLUSH};
    vecs[4]  = '{I_BR, O_FLUSH};
    vecs[5]  = '{I_NONE, O_RUN};
    vecs[6]  = '{I_MDS | I_MDD, O_GO};
    vecs[7]  = '{I_MDS, O_MDW};
    vecs[8]  = '{I_MDS | I_DREQ, O_MDW};
    vecs[9]  = '{I_MDS, O_MDW};
    vecs[10] = '{I_MDS, O_MDW};
    vecs[11] = '{I_MDS | I_MDD, O_MDW};
    vecs[12] = '{I_MDS, O_RUN};
    vecs[13] = '{I_NONE, O_RUN};
    vecs[14] = '{I_DREQ | I_BR, O_DFRZ};
    vecs[15] = '{I_DREQ | I_BR, O_MEMW};
    vecs[16] = '{I_DREQ | I_BR, O_MEMW};
    vecs[17] = '{I_DREQ | I_DACK | I_BR, O_MACK};
    vecs[18] = '{I_BR, O_FLUSH};
    vecs[19] = '{I_NONE, O_RUN};
    vecs[20] = '{I_DREQ | I_DACK, O_RUN};
    vecs[21] = '{I_NONE, O_RUN};

    // Reset held: outputs follow RUN rules immediately.
    @(negedge clk);
    #1;
    check("rst_outs", 32'(outs()), 32'(O_RUN));
    check("rst_cnt", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].in);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      check($sformatf("vec%0d_cnt", i), 32'(stall_cycles), 32'(exp_cnt));
      if (perf_en && !vecs[i].exp[8] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    end

    // Timeout: 8 MD_WAIT cycles, then sticky error.
    do_reset();
    step(I_MDS);
    check("to_go", 32'(md_go), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step(I_NONE);
      check($sformatf("to_wait%0d", k), 32'(state), 32'd2);
    end
    step(I_NONE);
    check("to_run", 32'(state), 32'd0);
    check("to_err", 32'(md_err), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(I_NONE);
      check($sformatf("to_err_hold%0d", k), 32'(md_err), 32'd1);
    end
    step(I_MDS);
    check("to_rego", 32'(md_go), 32'd1);
    step(I_NONE);
    check("to_rewait", 32'(state), 32'd2);

    // Asynchronous reset in the middle of MD_WAIT.
    #2;
    rst = 1'b1;
    #1;
    check("arst_md_state", 32'(state), 32'd0);
    check("arst_md_err", 32'(md_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(I_MDS);
    check("arst_md_rego", 32'(md_go), 32'd1);

    // Done and timeout coincide: treated as done.
    do_reset();
    step(I_MDS);
    check("tie_go", 32'(md_go), 32'd1);
    for (int k = 0; k < 7; k++) step(I_NONE);
    step(I_MDD);
    check("tie_last_wait", 32'(state), 32'd2);
    step(I_NONE);
    check("tie_run", 32'(state), 32'd0);
    check("tie_err", 32'(md_err), 32'd0);

    // Asynchronous reset in the middle of MEM_WAIT.
    do_reset();
    step(I_DREQ);
    step(I_DREQ);
    check("arst_mem_wait", 32'(state), 32'd1);
    #2;
    drive(I_NONE);
    rst = 1'b1;
    #1;
    check("arst_mem_state", 32'(state), 32'd0);
    check("arst_mem_pc_we", 32'(pc_we), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Counter saturation with a long stall run.
    do_reset();
    for (int k = 0; k < 20; k++) step(I_STL);
    step(I_NONE);
    check("cnt_sat", 32'(stall_cycles), perf_en ? 32'(CNT_MAX) : 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
